uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with mid-bit sampling.
// The start edge is detected on a double-synchronized copy of the line.
// After the start bit is confirmed at its midpoint, the bit counter is
// realigned so that every later sample lands mid-bit.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit
// between data bit 7 and the stop bit, plus a parity_err pulse output.
// Reset is synchronous and active-high. The port keeps the name rst_n.
module uart_rx_core #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       rx_done,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [7:0] rx_data
);

  localparam int          BIT_CYCLES = CLK_FREQ / BAUD;
  // Half a bit minus one: the start-bit midpoint, and the realignment point.
  localparam logic [12:0] MID_CNT    = 13'(BIT_CYCLES / 2 - 1);
  // After realignment, a full bit period lands each sample mid-bit.
  localparam logic [12:0] LAST_CNT   = 13'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity across data plus parity bit; a result of 1 means mismatch.
  function automatic logic parity_fail(input logic [7:0] data, input logic par);
    parity_fail = (^data) ^ par;
  endfunction
`endif

  logic       sync1_q;
  logic       sync2_q;
  logic       hist_q;
  logic       rx_s;
  logic       start_edge_s;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_done_q, rx_done_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  assign rx_s         = sync2_q;
  assign start_edge_s = hist_q & ~sync2_q;

  // Synchronizer and edge-history chain. These reset to idle-high so that
  // coming out of reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 13'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      rx_done_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rx_done_q <= rx_done_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, bit sampling and output loading.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rx_done_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = 13'd0;
        idx_d = 3'd0;
        if (start_edge_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == MID_CNT) begin
          // The counter restarts here, so the next sample is one bit later.
          cnt_d = 13'd0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            // The line went back high: this was a glitch, not a start bit.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 13'd0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 13'd0;
          par_d   = rx_s;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          // Return to IDLE at mid-stop so a back-to-back start edge is seen.
          cnt_d   = 13'd0;
          state_d = ST_IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            if (parity_fail(shift_q, par_q)) begin
              perr_d = 1'b1;
            end else begin
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
            end
`else
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
`endif
          end else begin
            // Framing error: drop the byte and keep the previous rx_data.
            rx_done_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 13'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign rx_done = rx_done_q;
  assign rx_data = rx_data_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core. The bench scales the baud rate so
// that one bit lasts 32 clocks, which keeps the run short.
module tb_uart_rx_core;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BC       = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       rx_done;
  logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_cnt = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int t0;

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rx_done   (rx_done),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  // Cycle counter used for the latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Count rx_done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_done", {31'd0, rx_done}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_state", {29'd0, dut.state_q}, 32'd0);
    check("reset_no_pulse", done_cnt, 32'd0);
    rst_n = 1'b0;
    repeat (2 * BC) @(negedge clk);

    // 8'h55, with exact latency: 2 sync + 9.5 bits + 1 = 307 clocks.
    t0 = cyc;
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    exp_cnt++;
    check("f55_count", done_cnt, exp_cnt);
    check("f55_data", {24'd0, rx_data}, 32'h55);
    check("f55_latency", last_done_cyc - t0, 32'd307);

    // Idle line for ten bit times: no activity.
    repeat (10 * BC) @(negedge clk);
    check("idle_count", done_cnt, exp_cnt);

    // Back-to-back 8'h0F and 8'hF0.
    send_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    exp_cnt++;
    check("f0f_count", done_cnt, exp_cnt);
    check("f0f_data", {24'd0, rx_data}, 32'h0F);
    send_frame(8'hF0, 1'b1);
    repeat (4) @(negedge clk);
    exp_cnt++;
    check("ff0_count", done_cnt, exp_cnt);
    check("ff0_data", {24'd0, rx_data}, 32'hF0);

    // Short low glitch, under half a bit: rejected at the start midpoint.
    repeat (2 * BC) @(negedge clk);
    uart_rx = 1'b0;
    repeat (BC / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * BC) @(negedge clk);
    check("glitch_count", done_cnt, exp_cnt);
    check("glitch_state", {29'd0, dut.state_q}, 32'd0);

    // Framing error on 8'hA5, then a valid 8'h3C.
    send_frame(8'hA5, 1'b0);
    repeat (2 * BC) @(negedge clk);
    check("ferr_count", done_cnt, exp_cnt);
    check("ferr_data", {24'd0, rx_data}, 32'hF0);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    exp_cnt++;
    check("f3c_count", done_cnt, exp_cnt);
    check("f3c_data", {24'd0, rx_data}, 32'h3C);

    // Break: line low for twelve bit times, then released.
    repeat (2 * BC) @(negedge clk);
    uart_rx = 1'b0;
    repeat (12 * BC) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BC) @(negedge clk);
    check("break_count", done_cnt, exp_cnt);
    check("break_data", {24'd0, rx_data}, 32'h3C);
    check("break_state", {29'd0, dut.state_q}, 32'd0);

    // Reset asserted after four data bits of 8'h55.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_done", {31'd0, rx_done}, 32'd0);
    check("mrst_data", {24'd0, rx_data}, 32'h00);
    check("mrst_state", {29'd0, dut.state_q}, 32'd0);
    check("mrst_count", done_cnt, exp_cnt);
    rst_n = 1'b0;
    repeat (2 * BC) @(negedge clk);
    check("mrst_idle_count", done_cnt, exp_cnt);
    send_frame(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    exp_cnt++;
    check("post_rst_count", done_cnt, exp_cnt);
    check("post_rst_data", {24'd0, rx_data}, 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
